// File: rtl/karatsuba_seq.sv
// rtl/karatsuba_seq.sv - sequential, resource-shared Karatsuba multiplier
//
// karatsuba #(W): combinational recursive Karatsuba multiplier, p = a * b.
//   a, b : W-bit unsigned operands
//   p    : 2W-bit product
//
// karatsuba_seq #(N): C = A * B using one karatsuba #(N/2) instance shared
// over three cycles (P3 = A_h*B_h, P2 = A_l*B_l, P1 = |A_l-A_h|*|B_h-B_l|).
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (A, B accepted when both high)
//   A, B                : N-bit unsigned operands
//   out_valid, out_ready: result handshake (C taken when both high)
//   C                   : registered 2N-bit product

module karatsuba #(
  parameter int W = 16
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  generate
    if (W == 1) begin : g_leaf
      assign p = {1'b0, a & b};
    end else begin : g_split
      localparam int H = W / 2;

      logic [H-1:0] a_h, a_l, b_h, b_l;
      logic         sgn_a, sgn_b, sgn;
      logic [H-1:0] abs_a, abs_b;
      logic [W-1:0] p_hh, p_ll, p_mm;
      logic [W:0]   sum_hl, mid;

      assign a_h = a[W-1:H];
      assign a_l = a[H-1:0];
      assign b_h = b[W-1:H];
      assign b_l = b[H-1:0];

      // Signs of (a_l - a_h) and (b_h - b_l); magnitudes always fit H bits.
      assign sgn_a = (a_l < a_h);
      assign sgn_b = (b_h < b_l);
      assign abs_a = sgn_a ? (a_h - a_l) : (a_l - a_h);
      assign abs_b = sgn_b ? (b_l - b_h) : (b_h - b_l);
      assign sgn   = sgn_a ^ sgn_b;

      karatsuba #(.W(H)) u_hh (.a(a_h),   .b(b_h),   .p(p_hh));
      karatsuba #(.W(H)) u_ll (.a(a_l),   .b(b_l),   .p(p_ll));
      karatsuba #(.W(H)) u_mm (.a(abs_a), .b(abs_b), .p(p_mm));

      // mid = a_h*b_l + a_l*b_h, never negative, fits W+1 bits.
      assign sum_hl = {1'b0, p_hh} + {1'b0, p_ll};
      assign mid    = sgn ? (sum_hl - {1'b0, p_mm}) : (sum_hl + {1'b0, p_mm});

      assign p = {p_hh, p_ll} + ({{(W-1){1'b0}}, mid} << H);
    end
  endgenerate

endmodule

module karatsuba_seq #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] C
);

  localparam int H = N / 2;

  typedef enum logic [2:0] {
    IDLE,
    MUL_H,
    MUL_L,
    MUL_M,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [H-1:0]   a_h_q, a_l_q, b_h_q, b_l_q;
  logic [H-1:0]   abs_a_m_q, abs_b_m_q;
  logic           sign_q;
  logic [N-1:0]   p3_q, p2_q;
  logic [2*N-1:0] c_q;

  // Operand differences at H+1 bits; the MSB is the sign.
  logic [H:0]     d_a, d_b;
  logic [H-1:0]   abs_a_in, abs_b_in;

  logic [H-1:0]   mul_a, mul_b;
  logic [N-1:0]   mul_p;
  logic [N:0]     sum_32, mid;
  logic [2*N-1:0] c_nxt;

  assign d_a = {1'b0, A[H-1:0]} - {1'b0, A[N-1:H]};
  assign d_b = {1'b0, B[N-1:H]} - {1'b0, B[H-1:0]};
  assign abs_a_in = d_a[H] ? (A[N-1:H] - A[H-1:0]) : d_a[H-1:0];
  assign abs_b_in = d_b[H] ? (B[H-1:0] - B[N-1:H]) : d_b[H-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = MUL_H;
      MUL_H:   state_nxt = MUL_L;
      MUL_L:   state_nxt = MUL_M;
      MUL_M:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state only; operand mux parks at zero when unused.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    mul_a     = '0;
    mul_b     = '0;
    case (state)
      MUL_H: begin
        mul_a = a_h_q;
        mul_b = b_h_q;
      end
      MUL_L: begin
        mul_a = a_l_q;
        mul_b = b_l_q;
      end
      MUL_M: begin
        mul_a = abs_a_m_q;
        mul_b = abs_b_m_q;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  karatsuba #(.W(H)) u_mul (
    .a(mul_a),
    .b(mul_b),
    .p(mul_p)
  );

  // In MUL_M the live product is P1.
  assign sum_32 = {1'b0, p3_q} + {1'b0, p2_q};
  assign mid    = sign_q ? (sum_32 - {1'b0, mul_p}) : (sum_32 + {1'b0, mul_p});
  assign c_nxt  = {p3_q, p2_q} + ({{(N-1){1'b0}}, mid} << H);

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_h_q     <= '0;
      a_l_q     <= '0;
      b_h_q     <= '0;
      b_l_q     <= '0;
      abs_a_m_q <= '0;
      abs_b_m_q <= '0;
      sign_q    <= 1'b0;
      p3_q      <= '0;
      p2_q      <= '0;
      c_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_h_q     <= A[N-1:H];
            a_l_q     <= A[H-1:0];
            b_h_q     <= B[N-1:H];
            b_l_q     <= B[H-1:0];
            abs_a_m_q <= abs_a_in;
            abs_b_m_q <= abs_b_in;
            sign_q    <= d_a[H] ^ d_b[H];
          end
        end
        MUL_H:   p3_q <= mul_p;
        MUL_L:   p2_q <= mul_p;
        MUL_M:   c_q  <= c_nxt;
        default: c_q  <= c_q;
      endcase
    end
  end

  assign C = c_q;

endmodule

// File: tb/tb_karatsuba_seq.sv
// tb/tb_karatsuba_seq.sv - bench for karatsuba_seq (N=32 directed, N=4 exhaustive)

module tb_karatsuba_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv0, ir0, ov0, or0;
  logic [31:0] a0, b0;
  logic [63:0] c0;
  logic        iv1, ir1, ov1, or1;
  logic [3:0]  a1, b1;
  logic [7:0]  c1;

  karatsuba_seq #(.N(32)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
    .out_valid(ov0), .out_ready(or0), .C(c0)
  );

  karatsuba_seq #(.N(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
    .out_valid(ov1), .out_ready(or1), .C(c1)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  // Model: at most one operation in flight per instance; product is a*b.
  bit          busy[2], seen[2], post_rst[2], rdy_next[2];
  logic [63:0] exp_c[2];
  int          acc_cyc[2], acc_cnt[2];
  int          acc_log[$];

  task automatic mon(input int i, input logic iv, input logic ir, input logic ov,
                     input logic ordy, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] c);
    if (post_rst[i]) begin
      chk("rst_out_valid", {63'b0, ov}, 64'd0);
      chk("rst_c", c, 64'd0);
      chk("rst_in_ready", {63'b0, ir}, 64'd1);
      post_rst[i] = 0;
      rdy_next[i] = 0;
    end
    if (rst) begin
      busy[i]     = 0;
      post_rst[i] = 1;
      return;
    end
    if (rdy_next[i]) begin
      chk("post_hs_in_ready", {63'b0, ir}, 64'd1);
      chk("post_hs_out_valid", {63'b0, ov}, 64'd0);
      rdy_next[i] = 0;
    end
    if (ov) begin
      if (!busy[i]) begin
        fail("spurious_out_valid");
      end else begin
        if (!seen[i]) begin
          chk("latency", 64'(cyc - acc_cyc[i]), 64'd4);
          seen[i] = 1;
        end
        chk("c_model", c, exp_c[i]);
        chk("in_ready_in_done", {63'b0, ir}, 64'd0);
        if (ordy) begin
          busy[i]     = 0;
          rdy_next[i] = 1;
        end
      end
    end else if (busy[i]) begin
      chk("out_valid_late", {63'b0, (cyc - acc_cyc[i]) < 4}, 64'd1);
      chk("in_ready_busy", {63'b0, ir}, 64'd0);
    end
    if (iv && ir) begin
      if (busy[i]) fail("accept_while_busy");
      busy[i]    = 1;
      seen[i]    = 0;
      exp_c[i]   = a * b;
      acc_cyc[i] = cyc;
      acc_cnt[i]++;
      if (i == 0) acc_log.push_back(cyc);
    end
  endtask

  always @(negedge clk) begin
    mon(0, iv0, ir0, ov0, or0, {32'b0, a0}, {32'b0, b0}, c0);
    mon(1, iv1, ir1, ov1, or1, {60'b0, a1}, {60'b0, b1}, {56'b0, c1});
  end

  task automatic do_op0(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] lit);
    int n;
    @(posedge clk); #1;
    a0 = a; b0 = b; iv0 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ir0 && n < 50) begin @(negedge clk); n++; end
    if (!ir0) fail("accept_timeout");
    @(posedge clk); #1;
    iv0 = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ov0 && n < 50) begin @(negedge clk); n++; end
    if (!ov0) fail("result_timeout");
    else chk("literal_c", c0, lit);
  endtask

  logic [31:0] pa[4];
  logic [31:0] pb[4];
  logic [63:0] saved;
  int          n;

  initial begin
    iv0 = 0; or0 = 1; a0 = 0; b0 = 0;
    iv1 = 0; or1 = 1; a1 = 0; b1 = 0;
    pa = '{32'h00000002, 32'hFFFF0000, 32'h80000001, 32'h7FFFFFFF};
    pb = '{32'h00000003, 32'h0000FFFF, 32'h00018000, 32'hFFFFFFFE};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready0", {63'b0, ir0}, 64'd1);
    chk("reset_out_valid0", {63'b0, ov0}, 64'd0);
    chk("reset_c0", c0, 64'd0);
    chk("reset_in_ready1", {63'b0, ir1}, 64'd1);
    chk("reset_c1", {56'b0, c1}, 64'd0);

    do_op0(32'h00010002, 32'h00030004, 64'h00000003000A0008);
    do_op0(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    do_op0(32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000);
    do_op0(32'h00010003, 32'h00050002, 64'h0000000500110006);

    // Back-pressure
    @(posedge clk); #1;
    or0 = 1'b0;
    do_op0(32'h00020003, 32'h00040005, 64'h000000080016000F);
    saved = c0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      a0 = 32'hCAFEBABE; b0 = 32'h13579BDF; iv0 = 1'b1;
      @(negedge clk);
      chk("bp_out_valid", {63'b0, ov0}, 64'd1);
      chk("bp_c_stable", c0, saved);
      chk("bp_in_ready", {63'b0, ir0}, 64'd0);
    end
    @(posedge clk); #1;
    or0 = 1'b1; iv0 = 1'b0;
    @(negedge clk);
    chk("bp_release_ov", {63'b0, ov0}, 64'd1);
    @(negedge clk);
    chk("bp_release_ir", {63'b0, ir0}, 64'd1);
    chk("bp_release_ov_low", {63'b0, ov0}, 64'd0);

    // Back-to-back with in_valid held high
    acc_log.delete();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      a0 = pa[k]; b0 = pb[k]; iv0 = 1'b1;
      n = 0;
      @(negedge clk);
      while (!ir0 && n < 50) begin @(negedge clk); n++; end
      if (!ir0) fail("b2b_accept_timeout");
    end
    @(posedge clk); #1;
    iv0 = 1'b0;
    n = 0;
    while (busy[0] && n < 50) begin @(negedge clk); n++; end
    if (busy[0]) fail("b2b_drain_timeout");
    chk("b2b_count", 64'(acc_log.size()), 64'd4);
    if (acc_log.size() == 4) begin
      for (int k = 1; k < 4; k++) chk("b2b_gap", 64'(acc_log[k] - acc_log[k-1]), 64'd5);
    end

    // Reset during MUL_L
    @(posedge clk); #1;
    a0 = 32'hDEADBEEF; b0 = 32'h0BADF00D; iv0 = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {63'b0, ir0}, 64'd1);
    @(posedge clk); #1;
    iv0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {63'b0, ov0}, 64'd0);
    chk("midrst_c", c0, 64'd0);
    chk("midrst_in_ready", {63'b0, ir0}, 64'd1);
    repeat (6) begin
      @(negedge clk);
      chk("aborted_never_shown", {63'b0, ov0}, 64'd0);
    end
    do_op0(32'h0000FFFF, 32'h00010000, 64'h0000FFFF00000000 >> 16);

    // N=4 exhaustive
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        @(posedge clk); #1;
        a1 = 4'(x); b1 = 4'(y); iv1 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ir1 && n < 50) begin @(negedge clk); n++; end
        if (!ir1) fail("exh_accept_timeout");
      end
    end
    @(posedge clk); #1;
    iv1 = 1'b0;
    n = 0;
    while (busy[1] && n < 50) begin @(negedge clk); n++; end
    if (busy[1]) fail("exh_drain_timeout");
    chk("exh_count", 64'(acc_cnt[1]), 64'd256);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
